// File: rtl/program_memory_loader_pkg.sv
// program_memory_loader_pkg: shared state encoding and byte/word geometry
package program_memory_loader_pkg;
    typedef enum logic [2:0] {IDLE, HEADER, RECEIVE, WRITE, DONE} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int ADDRESS_STEP = 4;
    localparam int BYTE_WIDTH = 8;
    localparam int WORD_WIDTH = BYTES_PER_WORD * BYTE_WIDTH;
endpackage

// File: rtl/program_memory_loader_word_assembler.sv
// word_assembler: big-endian shift register collecting four bytes into one word
module word_assembler
    import program_memory_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_full
);
    logic [1:0] count;
    // first byte ends up in the top byte lane after four shifts
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word <= '0;
            count <= '0;
        end else if (shift) begin
            word <= {word[WORD_WIDTH-BYTE_WIDTH-1:0], byte_data};
            count <= count + 2'd1;
        end
    end
    assign word_full = shift && count == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/program_memory_loader.sv
// program_memory_loader: receives a counted byte stream and writes it to program memory word by word
module program_memory_loader
    import program_memory_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int CW = $clog2(MEMORY_DEPTH) + 1;
    state_t state, next_state;
    logic [CW-1:0] word_count, target;
    logic [DATA_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0] word;
    logic error_flag, transfer, start_session, header_ok, shift, word_full;
    assign transfer = byte_valid && byte_ready;
    assign start_session = start && (state == IDLE || state == DONE);
    assign header_ok = byte_data != 8'd0 && 32'(byte_data) <= MEMORY_DEPTH;
    assign shift = state == RECEIVE && transfer;
    assign mem_address = address;
    assign mem_write_data = DATA_WIDTH'(word);

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_session),
        .shift     (shift),
        .byte_data (byte_data),
        .word      (word),
        .word_full (word_full)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end

    // next-state: byte_valid gaps simply hold the current state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = HEADER;
            HEADER:  if (transfer) next_state = header_ok ? RECEIVE : DONE;
            RECEIVE: if (word_full) next_state = WRITE;
            WRITE:   next_state = (word_count + CW'(1) == target) ? DONE : RECEIVE;
            DONE:    if (start) next_state = HEADER;
            default: next_state = IDLE;
        endcase
    end

    // word count, target length, write address and rejection flag
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= '0;
            target <= '0;
            address <= '0;
            error_flag <= 1'b0;
        end else begin
            if (start_session) begin
                word_count <= '0;
                address <= '0;
                error_flag <= 1'b0;
            end
            if (state == HEADER && transfer) begin
                target <= CW'(byte_data);
                error_flag <= !header_ok;
                address <= '0;
            end
            if (state == WRITE) begin
                word_count <= word_count + CW'(1);
                address <= address + DATA_WIDTH'(ADDRESS_STEP);
            end
        end
    end

    // outputs decoded from the current state
    always_comb begin
        byte_ready = state == HEADER || state == RECEIVE;
        mem_write_enable = state == WRITE;
        busy = state == HEADER || state == RECEIVE || state == WRITE;
        done = state == DONE;
        error = state == DONE && error_flag;
    end
endmodule

// File: tb/tb_program_memory_loader.sv
// tb_program_memory_loader: randomized and directed sessions checked against a byte-stream model
module tb_program_memory_loader;
    localparam int DEPTH = 32;
    localparam int W = 32;
    typedef struct {logic [W-1:0] a; logic [W-1:0] d;} wr_t;

    logic clk = 0, reset = 1, start = 0, byte_valid = 0;
    logic [7:0] byte_data = 0;
    logic byte_ready, mem_write_enable, busy, done, error;
    logic [W-1:0] mem_address, mem_write_data;
    int errors = 0, checks = 0, cyc = 0;
    wr_t got[$];

    program_memory_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // capture every write and check it stays aligned and inside the memory
    always @(negedge clk) begin
        if (mem_write_enable) begin
            got.push_back('{mem_address, mem_write_data});
            checks++;
            if (mem_address > W'(4 * (DEPTH - 1)) || mem_address[1:0] != 2'b00) begin
                errors++;
                $display("FAIL addr_bound: got %h, required aligned and <= %h", mem_address, 4 * (DEPTH - 1));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        int t;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 0; byte_data = 8'($urandom); start = st;
        end
        @(negedge clk);
        byte_valid = 1; byte_data = b; start = st;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL byte_accept: byte_ready stayed %b, required 1", byte_ready);
        end
        @(posedge clk);
    endtask

    task automatic start_pulse(output int c);
        @(negedge clk);
        start = 1; byte_valid = 0;
        @(posedge clk);
        #1 start = 0;
        c = cyc;
    endtask

    task automatic wait_done(output int c);
        int t = 0;
        do begin
            @(negedge clk);
            byte_valid = 0; start = 0;
            t++;
        end while (!done && t < 2000);
        c = cyc;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({byte_ready, mem_write_enable, busy, done, error} !== 5'b0 || mem_address !== '0 || mem_write_data !== '0) begin
            errors++;
            $display("FAIL %s: got ready/we/busy/done/err=%b addr=%h data=%h, required all 0", name,
                     {byte_ready, mem_write_enable, busy, done, error}, mem_address, mem_write_data);
        end
    endtask

    // one full session: the model expects word i = bytes 4i..4i+3 big-endian at address 4i
    task automatic run_session(input int n, input logic [7:0] body[$], input int gap, input bit hold);
        int t0, t1, nexp, g;
        logic exp_err;
        logic [W-1:0] exp_word;
        got.delete();
        start_pulse(t0);
        checks++;
        if (done !== 0 || error !== 0 || busy !== 1) begin
            errors++;
            $display("FAIL session_start: got done=%b err=%b busy=%b, required 0 0 1", done, error, busy);
        end
        g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
        send_byte(8'(n), g, 1'b0);
        foreach (body[i]) begin
            g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
            send_byte(body[i], g, hold && i >= 2 && i < 6);
        end
        wait_done(t1);
        exp_err = !(n >= 1 && n <= DEPTH);
        nexp = exp_err ? 0 : n;
        checks++;
        if (done !== 1) begin
            errors++;
            $display("FAIL done_flag: got %b, required 1", done);
        end
        checks++;
        if (error !== exp_err) begin
            errors++;
            $display("FAIL error_flag n=%0d: got %b, required %b", n, error, exp_err);
        end
        checks++;
        if (busy !== 0 || byte_ready !== 0) begin
            errors++;
            $display("FAIL done_idle: got busy=%b ready=%b, required 0 0", busy, byte_ready);
        end
        checks++;
        if (got.size() != nexp) begin
            errors++;
            $display("FAIL write_count n=%0d: got %0d, required %0d", n, got.size(), nexp);
        end
        for (int i = 0; i < nexp && i < got.size(); i++) begin
            exp_word = {body[4*i], body[4*i+1], body[4*i+2], body[4*i+3]};
            checks++;
            if (got[i].a !== W'(4 * i) || got[i].d !== exp_word) begin
                errors++;
                $display("FAIL write_%0d: got %h@%h, required %h@%h", i, got[i].d, got[i].a, exp_word, 4 * i);
            end
        end
        if (gap == 0 && !hold) begin
            checks++;
            if (t1 - t0 != (exp_err ? 1 : 1 + 5 * n)) begin
                errors++;
                $display("FAIL session_len n=%0d: got %0d cycles, required %0d", n, t1 - t0, exp_err ? 1 : 1 + 5 * n);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset_state");
        @(negedge clk);
        start = 1; byte_valid = 1; byte_data = 8'h01;
        @(posedge clk);
        #1 check_idle_outputs("reset_priority");
        @(negedge clk);
        reset = 0; start = 0; byte_valid = 0;
    endtask

    task automatic test_directed();
        logic [7:0] d[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
        logic [7:0] q[$];
        foreach (d[i]) q.push_back(d[i]);
        run_session(2, q, 0, 0);
    endtask

    task automatic test_bad_header();
        logic [7:0] q[$];
        run_session(0, q, 0, 0);
        run_session(33, q, 0, 0);
    endtask

    task automatic test_full_depth();
        logic [7:0] q[$];
        for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'($urandom));
        run_session(DEPTH, q, 1, 0);
        checks++;
        if (got.size() == 0 || got[got.size()-1].a !== W'(32'h7C)) begin
            errors++;
            $display("FAIL last_addr: got %h, required 0000007c", got.size() ? got[got.size()-1].a : '1);
        end
    endtask

    task automatic test_reset_mid_word();
        int t0;
        logic [7:0] q[$];
        start_pulse(t0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        @(negedge clk);
        byte_valid = 1; byte_data = 8'h33; reset = 1;
        @(posedge clk);
        #1 check_idle_outputs("reset_mid_word");
        @(negedge clk);
        reset = 0; byte_valid = 0;
        q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_session(1, q, 0, 0);
    endtask

    task automatic test_start_ignored();
        logic [7:0] q[$];
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        run_session(3, q, 0, 1);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int n;
        for (int s = 0; s < 8; s++) begin
            q.delete();
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(33, 255)) * int'($urandom_range(0, 1)) : int'($urandom_range(1, 8));
            if (n >= 1 && n <= DEPTH) for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            run_session(n, q, -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bad_header();
        test_full_depth();
        test_reset_mid_word();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/program_memory_loader.md
PROGRAM_MEMORY_LOADER -- requirements
Module: program_memory_loader

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32, is the program memory size in words.
REQ-002 Parameter DATA_WIDTH, default 32, is the instruction word and address width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a load session; sampled in IDLE or DONE only.
REQ-006 byte_valid  input  1  byte_data holds a valid byte this cycle.
REQ-007 byte_data  input  8  incoming program byte stream.
REQ-008 byte_ready  output  1  loader accepts byte_data this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-009 mem_write_enable  output  1  one-cycle write strobe to program memory.
REQ-010 mem_address  output  DATA_WIDTH  byte address of the word being written, always word-aligned (bits [1:0] = 0).
REQ-011 mem_write_data  output  DATA_WIDTH  assembled instruction word.
REQ-012 busy  output  1  high in HEADER, RECEIVE and WRITE.
REQ-013 done  output  1  high while in DONE.
REQ-014 error  output  1  high in DONE when the session was rejected.

Function
REQ-015 The FSM has states IDLE, HEADER, RECEIVE, WRITE and DONE.
REQ-016 IDLE -> HEADER on start; start is ignored in HEADER, RECEIVE and WRITE.
REQ-017 HEADER: byte_ready is 1, and the first accepted byte is the word count N.
REQ-018 If 1 <= N <= MEMORY_DEPTH, HEADER -> RECEIVE with mem_address = 0; otherwise HEADER -> DONE with error = 1 and no memory write.
REQ-019 RECEIVE: byte_ready is 1, and each accepted byte shifts into the word, first byte = bits [31:24] (big-endian).
REQ-020 After the 4th accepted byte of a word, RECEIVE -> WRITE on the next edge; byte_ready is 0 in WRITE.
REQ-021 WRITE lasts exactly one cycle, with mem_write_enable = 1 and stable mem_address and mem_write_data.
REQ-022 On leaving WRITE, mem_address increments by 4; if N words have been written, go to DONE with error = 0, else return to RECEIVE.
REQ-023 Cycles with byte_valid = 0 stall the FSM in place, with no timeout.
REQ-024 Bytes presented while byte_ready = 0 are not consumed.
REQ-025 DONE: byte_ready is 0; start -> HEADER clears done and error and resets the word and byte counters.
REQ-026 mem_address never exceeds 4*(MEMORY_DEPTH-1) during a write.
REQ-027 mem_write_enable is asserted exactly N times per accepted session.
REQ-028 Minimum session length is 1 + 5N cycles after HEADER entry, given continuous byte_valid.

Reset
REQ-029 reset on any edge forces IDLE, regardless of state, including mid-word or in WRITE.
REQ-030 Reset values: byte_ready, mem_write_enable, busy, done and error = 0; mem_address and mem_write_data = 0; internal counters = 0.
REQ-031 A partially assembled word is discarded on reset and never written.
REQ-032 reset has priority over start and byte_valid in the same cycle.

Structure
REQ-033 The shared package holds the state enumeration, BYTES_PER_WORD = 4, ADDRESS_STEP = 4 and the byte width 8.
REQ-034 One sub-module, word_assembler, holds the 4-byte shift register and 2-bit byte counter, with clear, shift and word_full ports.
REQ-035 The top level holds the FSM, the word counter (width clog2(MEMORY_DEPTH)+1) and the address register.

Verification
REQ-036 Scenario: start, then bytes 02, 20 08 00 05, 8C 09 00 00 with continuous valid -> writes 0x20080005 @0x0 and 0x8C090000 @0x4, then done = 1, error = 0.
REQ-037 Scenario: header 00 -> DONE, error = 1, zero writes; header 21 (33 > 32) -> same result.
REQ-038 Scenario: N = 32 with valid toggled every other cycle -> 32 writes, the last at 0x7C, and no write beyond it.
REQ-039 Scenario: reset asserted after the 2nd byte of word 1 -> IDLE next cycle with all outputs 0; a new start plus header 01 and word AABBCCDD -> one write of 0xAABBCCDD @0x0.
REQ-040 Scenario: start pulsed during RECEIVE, and byte_valid held high during WRITE -> start is ignored, the held byte is accepted only after WRITE, and the data is uncorrupted.
REQ-041 Scenario: start in DONE -> done and error clear, HEADER is re-entered, and the second session writes from address 0x0.
